// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive sampler/deserializer.
// Build option: define UART_RX_VOTE5_EN for a 5-sample vote (Prescale 16 or 32 only).
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  // Bit index within a frame, as reported by the edge/bit counter
  localparam logic [3:0] START_IDX      = 4'd0;
  localparam logic [3:0] FIRST_DATA_IDX = 4'd1;
  localparam logic [3:0] LAST_DATA_IDX  = 4'd8;
  localparam logic [3:0] PAR_IDX        = 4'd9;
  localparam logic [3:0] STOP_IDX_NOPAR = 4'd9;
  localparam logic [3:0] STOP_IDX_PAR   = 4'd10;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

`ifdef UART_RX_VOTE5_EN
  localparam int unsigned NUM_SAMPLES = 5;
`else
  localparam int unsigned NUM_SAMPLES = 3;
`endif

  // True when more than half of the first n bits of s are set
  function automatic logic majority(input logic [4:0] s, input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(n)) cnt += {31'b0, s[i]};
    end
    return (2 * cnt) > n;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_deser_if.sv
// Result bundle of the sampler/deserializer towards the receiver FSM and data sink.
interface uart_rx_sampler_deser_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sampled_bit;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output sampled_bit, sample_valid, P_DATA, data_valid, strt_glitch, par_err, stp_err
  );

  modport slave (
    input sampled_bit, sample_valid, P_DATA, data_valid, strt_glitch, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_majority_vote.sv
// Captures RX_IN around mid-bit and majority-votes the samples once per bit.
// Sample count is 3, or 5 when UART_RX_VOTE5_EN is defined.
module uart_rx_majority_vote #(
  parameter int unsigned Prescale_Width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      halt,
  input  logic                      RX_IN,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic [Prescale_Width-1:0] edge_cnt,
  output logic                      decide,
  output logic                      vote,
  output logic                      sampled_bit,
  output logic                      sample_valid
);
  import uart_rx_pkg::*;

  localparam int unsigned Half = (NUM_SAMPLES - 1) / 2;

  logic [Prescale_Width-1:0] mid, first_pt, dec_pt;
  logic [NUM_SAMPLES-1:0]    samp_q;
  logic                      sampled_bit_q, sample_valid_q;

  assign mid      = Prescale >> 1;
  assign first_pt = mid - Prescale_Width'(Half);
  assign dec_pt   = first_pt + Prescale_Width'(NUM_SAMPLES);

  assign vote   = majority(5'(samp_q), NUM_SAMPLES);
  // Once a start glitch is seen the rest of the frame produces no decisions
  assign decide = enable && !halt && (edge_cnt == dec_pt);

  // Sample capture window; cleared whenever the frame is inactive
  always_ff @(posedge CLK) begin
    if (RST || !enable) begin
      samp_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
        if (edge_cnt == first_pt + Prescale_Width'(i)) samp_q[i] <= RX_IN;
      end
    end
  end

  // Voted bit register and its one-cycle valid pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= decide;
      if (decide) sampled_bit_q <= vote;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: rtl/uart_rx_sampler_deser.sv
// UART receive sampler/deserializer: votes each bit, shifts data LSB first,
// checks start/parity/stop and presents P_DATA with a one-cycle data_valid.
// Build option: UART_RX_VOTE5_EN selects the 5-sample vote in uart_rx_majority_vote.
module uart_rx_sampler_deser #(
  parameter int unsigned Prescale_Width = 6,
  parameter int unsigned DATA_WIDTH     = uart_rx_pkg::DATA_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      enable,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [Prescale_Width-1:0] edge_cnt,
  input  logic [3:0]                bit_cnt,
  uart_rx_sampler_deser_if.master   rx_if
);
  import uart_rx_pkg::*;

  logic                  decide, vote;
  logic                  sampled_bit, sample_valid;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
  logic                  glitch_q, glitch_d, par_seen_q, par_seen_d;
  logic                  load_q, load_d;
  logic                  dv_q, dv_d, strt_q, strt_d, par_err_q, par_err_d, stp_q, stp_d;
  logic                  par_exp, is_stop, is_data;

  uart_rx_majority_vote #(
    .Prescale_Width (Prescale_Width)
  ) u_vote (
    .CLK          (CLK),
    .RST          (RST),
    .enable       (enable),
    .halt         (glitch_q),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .edge_cnt     (edge_cnt),
    .decide       (decide),
    .vote         (vote),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  assign par_exp = (PAR_TYP == PAR_EVEN) ? ^shift_q : ~^shift_q;
  assign is_data = (bit_cnt >= FIRST_DATA_IDX) && (bit_cnt <= LAST_DATA_IDX);
  assign is_stop = (!PAR_EN && bit_cnt == STOP_IDX_NOPAR) || (PAR_EN && bit_cnt == STOP_IDX_PAR);

  // Per-bit actions at the vote decision and the deferred P_DATA load
  always_comb begin
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    glitch_d   = glitch_q;
    par_seen_d = par_seen_q;
    load_d     = 1'b0;
    dv_d       = 1'b0;
    strt_d     = 1'b0;
    par_err_d  = 1'b0;
    stp_d      = 1'b0;
    if (!enable) begin
      shift_d    = '0;
      glitch_d   = 1'b0;
      par_seen_d = 1'b0;
    end else begin
      if (load_q) begin
        pdata_d = shift_q;
        dv_d    = 1'b1;
      end
      if (decide) begin
        if (bit_cnt == START_IDX) begin
          if (vote) begin
            strt_d   = 1'b1;
            glitch_d = 1'b1;
          end
        end else if (is_data) begin
          shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        end else if (PAR_EN && bit_cnt == PAR_IDX) begin
          if (vote != par_exp) begin
            par_err_d  = 1'b1;
            par_seen_d = 1'b1;
          end
        end else if (is_stop) begin
          if (!vote) stp_d = 1'b1;
          else if (!par_seen_q) load_d = 1'b1;
        end
      end
    end
  end

  // State and output pulse registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q    <= '0;
      pdata_q    <= '0;
      glitch_q   <= 1'b0;
      par_seen_q <= 1'b0;
      load_q     <= 1'b0;
      dv_q       <= 1'b0;
      strt_q     <= 1'b0;
      par_err_q  <= 1'b0;
      stp_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      pdata_q    <= pdata_d;
      glitch_q   <= glitch_d;
      par_seen_q <= par_seen_d;
      load_q     <= load_d;
      dv_q       <= dv_d;
      strt_q     <= strt_d;
      par_err_q  <= par_err_d;
      stp_q      <= stp_d;
    end
  end

  assign rx_if.sampled_bit  = sampled_bit;
  assign rx_if.sample_valid = sample_valid;
  assign rx_if.P_DATA       = pdata_q;
  assign rx_if.data_valid   = dv_q;
  assign rx_if.strt_glitch  = strt_q;
  assign rx_if.par_err      = par_err_q;
  assign rx_if.stp_err      = stp_q;

endmodule

// File: tb/tb_uart_rx_sampler_deser.sv
// Directed bench for uart_rx_sampler_deser: drives edge/bit counts and RX_IN per frame,
// tallies output pulses with their (bit, edge) position and compares to hand values.
module tb_uart_rx_sampler_deser;

`ifdef UART_RX_VOTE5_EN
  localparam int DecOff = 3;
`else
  localparam int DecOff = 2;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       enable = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] edge_cnt = '0;
  logic [3:0] bit_cnt = '0;

  uart_rx_sampler_deser_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_sampler_deser #(
    .Prescale_Width (6),
    .DATA_WIDTH     (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .enable   (enable),
    .Prescale (Prescale),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .rx_if    (rx_if)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse tallies for the current frame; positions encoded as bit*256+edge
  int         n_sv, n_svd, n_dv, n_glitch, n_par, n_stp;
  int         dv_pos, glitch_pos, par_pos, stp_pos;
  logic [7:0] rec_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_sv = 0; n_svd = 0; n_dv = 0; n_glitch = 0; n_par = 0; n_stp = 0;
    dv_pos = -1; glitch_pos = -1; par_pos = -1; stp_pos = -1;
    rec_byte = '0;
  endtask

  // One clock: drive on negedge, observe 1 time unit after the posedge
  task automatic step(input logic rx, input int bc, input int ec, input logic en);
    int pos;
    @(negedge CLK);
    RX_IN = rx; bit_cnt = 4'(bc); edge_cnt = 6'(ec); enable = en;
    @(posedge CLK);
    #1;
    pos = bc * 256 + ec;
    if (rx_if.sample_valid) begin
      n_sv++;
      if (bc >= 1 && bc <= 8) begin
        n_svd++;
        rec_byte[bc-1] = rx_if.sampled_bit;
      end
    end
    if (rx_if.data_valid) begin n_dv++; if (dv_pos < 0) dv_pos = pos; end
    if (rx_if.strt_glitch) begin n_glitch++; if (glitch_pos < 0) glitch_pos = pos; end
    if (rx_if.par_err) begin n_par++; if (par_pos < 0) par_pos = pos; end
    if (rx_if.stp_err) begin n_stp++; if (stp_pos < 0) stp_pos = pos; end
  endtask

  task automatic send_frame(input int presc, input logic pen, input logic ptyp,
                            input logic [7:0] data, input logic pbit, input logic stopv,
                            input logic startv, input int gbit, input logic [31:0] gmask,
                            input int abort_bit);
    int   nbits;
    logic val;
    Prescale = 6'(presc); PAR_EN = pen; PAR_TYP = ptyp;
    clear_counts();
    nbits = pen ? 11 : 10;
    for (int b = 0; b < nbits; b++) begin
      if (b == abort_bit) return;
      if (b == 0) val = startv;
      else if (b <= 8) val = data[b-1];
      else if (pen && b == 9) val = pbit;
      else val = stopv;
      for (int e = 0; e < presc; e++) begin
        step((b == gbit && gmask[e]) ? ~val : val, b, e, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 15, 0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 0, 0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pdata"}, 32'(rx_if.P_DATA), 32'h0);
    check({tag, "_pulses"}, {26'b0, rx_if.sampled_bit, rx_if.sample_valid, rx_if.data_valid,
          rx_if.strt_glitch, rx_if.par_err, rx_if.stp_err}, 32'h0);
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 1'b0);
    check_outputs_zero("reset");
    RST = 1'b0;

    // Clean 0xA5, Prescale 8, no parity
    send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, -1, 32'h0, -1);
    check("a5_pdata", 32'(rx_if.P_DATA), 32'hA5);
    check("a5_data_sv", n_svd, 8);
    check("a5_total_sv", n_sv, 10);
    check("a5_voted_byte", 32'(rec_byte), 32'hA5);
    check("a5_dv_count", n_dv, 1);
    check("a5_dv_pos", dv_pos, 9 * 256 + 4 + DecOff + 1);
    check("a5_errors", n_glitch + n_par + n_stp, 0);
    check("a5_last_bit", 32'(rx_if.sampled_bit), 32'h1);

    // 0xFF, data bit 3 (bit_cnt 4) glitched at edge 4 only: vote keeps 1
    send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 4, 32'h10, -1);
    check("ff_mid_glitch", 32'(rx_if.P_DATA), 32'hFF);
    // Glitched at edges 3 and 5: two of three samples 0
    send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 4, 32'h28, -1);
    check("ff_two_glitch", 32'(rx_if.P_DATA), 32'hF7);
    // Glitched outside the window (edges 2 and 6): no effect
    send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 4, 32'h44, -1);
    check("ff_outside_glitch", 32'(rx_if.P_DATA), 32'hFF);
    check("ff_dv_count", n_dv, 1);

    // Prescale 16, even parity, 0x0F with wrong parity bit 1
    send_frame(16, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, -1, 32'h0, -1);
    check("par_err_count", n_par, 1);
    check("par_err_pos", par_pos, 9 * 256 + 8 + DecOff);
    check("par_no_dv", n_dv, 0);
    check("par_pdata_held", 32'(rx_if.P_DATA), 32'hFF);
    check("par_no_stp", n_stp, 0);

    // Prescale 16, odd parity, 0x0F with correct parity bit 1
    send_frame(16, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, -1, 32'h0, -1);
    check("odd_par_ok", n_par, 0);
    check("odd_pdata", 32'(rx_if.P_DATA), 32'h0F);
    check("odd_dv_pos", dv_pos, 10 * 256 + 8 + DecOff + 1);

    // 0x3C with stop bit 0
    send_frame(8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 32'h0, -1);
    check("stp_count", n_stp, 1);
    check("stp_pos", stp_pos, 9 * 256 + 4 + DecOff);
    check("stp_no_dv", n_dv, 0);
    check("stp_pdata_held", 32'(rx_if.P_DATA), 32'h0F);

    // Start bit high: glitch pulse, then nothing else for the frame (stop 0 too)
    send_frame(8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, -1, 32'h0, -1);
    check("glitch_count", n_glitch, 1);
    check("glitch_pos", glitch_pos, 0 * 256 + 4 + DecOff);
    check("glitch_sv_only_start", n_sv, 1);
    check("glitch_no_more", n_dv + n_par + n_stp, 0);

    // Reset mid-frame at bit 5, then a clean 0x81
    send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, -1, 32'h0, 5);
    RST = 1'b1;
    step(1'b1, 5, 0, 1'b1);
    check_outputs_zero("midreset");
    RST = 1'b0;
    step(1'b1, 0, 0, 1'b0);
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, -1, 32'h0, -1);
    check("post_reset_pdata", 32'(rx_if.P_DATA), 32'h81);
    check("post_reset_dv", n_dv, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
